// File: rtl/coax_tx_scheduler.sv
// Two-requester frame scheduler feeding a coax_tx word serializer, with an enforced inter-frame gap.
// Define COAX_TX_SCHEDULER_ROUND_ROBIN_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module coax_tx_scheduler #(
  parameter int GAP_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [9:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [9:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       tx_load,
  output logic [9:0] tx_data,
  input  logic       tx_full,
  input  logic       tx_active,
  output logic [1:0] grant,
  output logic       busy
);

  // Counter must reach GAP_CYCLES itself on the final gap cycle without wrapping.
  localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES == 0) ? '0 : GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, GAP} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   gap_cnt;
  logic            drain_seen;
  logic            accept;
  logic            drain_exit;
  logic            pick1;
  logic            g_valid;
  logic            g_last;
  logic [9:0]      g_data;

`ifdef COAX_TX_SCHEDULER_ROUND_ROBIN_EN
  logic rr_ptr;

  always_comb begin
    pick1 = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
  end

  // The pointer only moves once the requester it names has finished a frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= 1'b0;
    end else if (drain_exit && (grant[1] == rr_ptr)) begin
      rr_ptr <= ~rr_ptr;
    end
  end
`else
  always_comb begin
    pick1 = ~req0_valid;
  end
`endif

  always_comb begin
    g_valid = (grant[0] & req0_valid) | (grant[1] & req1_valid);
    g_last  = grant[1] ? req1_last : req0_last;
    g_data  = grant[1] ? req1_data : req0_data;
  end

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    drain_exit = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) state_d = STREAM;
      end
      STREAM: begin
        // The tx_load term spaces accepted words at least two cycles apart.
        if (g_valid && !tx_full && !tx_load) begin
          accept = 1'b1;
          if (g_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_seen && !tx_active && !tx_full) begin
          drain_exit = 1'b1;
          state_d    = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant      <= 2'b00;
      tx_load    <= 1'b0;
      tx_data    <= '0;
      gap_cnt    <= '0;
      drain_seen <= 1'b0;
    end else begin
      tx_load <= accept;
      if (accept) tx_data <= g_data;
      // High from the second DRAIN cycle on, giving DRAIN its two-cycle minimum.
      drain_seen <= (state_q == DRAIN);
      gap_cnt    <= (state_q == GAP) ? gap_cnt + 1'b1 : '0;
      if (state_q == IDLE && (req0_valid || req1_valid)) begin
        grant <= pick1 ? 2'b10 : 2'b01;
      end else if (drain_exit) begin
        grant <= 2'b00;
      end
    end
  end

  assign req0_ready = accept & grant[0];
  assign req1_ready = accept & grant[1];
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_coax_tx_scheduler.sv
// Self-checking bench for coax_tx_scheduler: cycle table, hand-written corner sequences and
// randomized traffic checked against a frame/word-level model of the scheduling rules.
module tb_coax_tx_scheduler;

  localparam int GAP = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid;
  logic [9:0] req0_data, req1_data;
  logic       req0_last, req1_last;
  logic       req0_ready, req1_ready;
  logic       tx_load;
  logic [9:0] tx_data;
  logic       tx_full, tx_active;
  logic [1:0] grant;
  logic       busy;

  coax_tx_scheduler #(.GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .tx_load(tx_load), .tx_data(tx_data), .tx_full(tx_full), .tx_active(tx_active),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         rep;
    logic       v;
    logic [9:0] d;
    logic       l;
    logic       full;
    logic       act;
    logic       rdy;
    logic       load;
    logic [9:0] data;
    logic [1:0] gnt;
    logic       bsy;
  } vec_t;

  typedef struct {
    logic [9:0] d;
    logic       l;
  } word_t;

  vec_t       tbl[11];
  word_t      q0[$];
  word_t      q1[$];
  logic [9:0] exp_q[$];
  logic [1:0] order[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_data = '0; req0_last = 1'b0;
    req1_valid = 1'b0; req1_data = '0; req1_last = 1'b0;
    tx_full = 1'b0; tx_active = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) next();
    reset = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n = 0;
    while (busy && n < limit) begin
      next();
      n++;
    end
    check(name, busy, 0);
  endtask

  // Frame-level reference: queued words leave only through ready, each accepted word must
  // appear once on tx_load in order, frames never interleave, and every gap lasts GAP cycles.
  task automatic run_auto(input bit rnd, input int limit);
    int         cyc = 0;
    int         gap_run = 0;
    logic [1:0] prev_grant = 2'b00;
    logic       prev_load = 1'b0;
    bit         in_frame = 0;
    bit         done = 0;
    order.delete();
    exp_q.delete();
    while (!done && cyc < limit) begin
      word_t w;
      int    n;
      req0_valid = (q0.size() > 0) && (!rnd || $urandom_range(3) != 0);
      if (q0.size() > 0) begin req0_data = q0[0].d; req0_last = q0[0].l; end
      req1_valid = (q1.size() > 0) && (!rnd || $urandom_range(3) != 0);
      if (q1.size() > 0) begin req1_data = q1[0].d; req1_last = q1[0].l; end
      tx_full   = rnd && ($urandom_range(3) == 0);
      tx_active = rnd && ($urandom_range(2) == 0);
      mid();
      if (req0_ready || req1_ready) begin
        n = req1_ready ? 1 : 0;
        check("ready_exclusive", req0_ready & req1_ready, 0);
        check("ready_granted", grant, (n == 1) ? 2'b10 : 2'b01);
        check("ready_valid", (n == 1) ? req1_valid : req0_valid, 1);
        check("ready_full", tx_full, 0);
        check("ready_load", tx_load, 0);
        if (n == 0 && q0.size() > 0) begin
          w = q0.pop_front();
          exp_q.push_back(w.d);
          in_frame = !w.l;
        end else if (n == 1 && q1.size() > 0) begin
          w = q1.pop_front();
          exp_q.push_back(w.d);
          in_frame = !w.l;
        end
      end
      if (tx_load) begin
        check("load_spacing", prev_load, 0);
        check("load_pending", exp_q.size(), 1);
        if (exp_q.size() > 0) check("load_data", tx_data, exp_q.pop_front());
      end
      check("grant_onehot", grant == 2'b11, 0);
      if (prev_grant == 2'b00 && grant != 2'b00) order.push_back(grant);
      if (prev_grant != 2'b00 && grant != prev_grant) begin
        check("frame_atomic", in_frame, 0);
        check("grant_release", grant, 2'b00);
      end
      if (busy && grant == 2'b00) begin
        gap_run++;
      end else if (gap_run > 0) begin
        check("gap_len", gap_run, GAP);
        gap_run = 0;
      end
      prev_grant = grant;
      prev_load  = tx_load;
      done = (q0.size() == 0) && (q1.size() == 0) && (exp_q.size() == 0) && !busy && (gap_run == 0);
      next();
      cyc++;
    end
    check("auto_done", done, 1);
    idle_inputs();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_order[4];
    int         nf;

    // Cycle table: single three-word frame from requester 0, then the full gap.
    //              rep  v     d        l     full  act  | rdy   load  data     gnt    bsy
    tbl[0]  = '{1,   1'b1, 10'h031, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 2'b00, 1'b0};
    tbl[1]  = '{1,   1'b1, 10'h031, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h000, 2'b01, 1'b1};
    tbl[2]  = '{1,   1'b1, 10'h29C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'h031, 2'b01, 1'b1};
    tbl[3]  = '{1,   1'b1, 10'h29C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'h031, 2'b01, 1'b1};
    tbl[4]  = '{1,   1'b1, 10'h212, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 10'h29C, 2'b01, 1'b1};
    tbl[5]  = '{1,   1'b1, 10'h212, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'h29C, 2'b01, 1'b1};
    tbl[6]  = '{1,   1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'h212, 2'b01, 1'b1};
    tbl[7]  = '{1,   1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h212, 2'b01, 1'b1};
    tbl[8]  = '{1,   1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h212, 2'b01, 1'b1};
    tbl[9]  = '{GAP, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h212, 2'b00, 1'b1};
    tbl[10] = '{2,   1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h212, 2'b00, 1'b0};

    // Reset state, with a request present that must be ignored.
    idle_inputs();
    reset = 1'b1;
    req0_valid = 1'b1;
    repeat (2) mid();
    check("rst_grant", grant, 2'b00);
    check("rst_busy", busy, 0);
    check("rst_load", tx_load, 0);
    check("rst_data", tx_data, 0);
    check("rst_ready", {req1_ready, req0_ready}, 2'b00);
    next();
    do_reset();

    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].rep; r++) begin
        req0_valid = tbl[i].v; req0_data = tbl[i].d; req0_last = tbl[i].l;
        tx_full = tbl[i].full; tx_active = tbl[i].act;
        mid();
        check($sformatf("tbl%0d_ready0", i), req0_ready, tbl[i].rdy);
        check($sformatf("tbl%0d_ready1", i), req1_ready, 0);
        check($sformatf("tbl%0d_load", i), tx_load, tbl[i].load);
        check($sformatf("tbl%0d_data", i), tx_data, tbl[i].data);
        check($sformatf("tbl%0d_grant", i), grant, tbl[i].gnt);
        check($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
        next();
      end
    end

    // Backpressure: tx_full high for 10 cycles between words.
    do_reset();
    req0_valid = 1'b1; req0_data = 10'h155;
    mid(); next();
    mid(); check("bp_accept0", req0_ready, 1); next();
    req0_data = 10'h0AA;
    mid(); check("bp_load0", tx_load, 1); check("bp_data0", tx_data, 10'h155); next();
    tx_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      mid();
      check("bp_stall_ready", req0_ready, 0);
      check("bp_stall_load", tx_load, 0);
      next();
    end
    tx_full = 1'b0;
    mid(); check("bp_release_ready", req0_ready, 1); next();
    req0_data = 10'h3C3; req0_last = 1'b1;
    mid(); check("bp_held_load", tx_load, 1); check("bp_held_data", tx_data, 10'h0AA); next();
    mid(); check("bp_last_ready", req0_ready, 1); next();
    req0_valid = 1'b0; req0_last = 1'b0;
    mid(); check("bp_last_data", tx_data, 10'h3C3); next();
    wait_idle("bp_idle", 200);

    // Drain: tx_active held for 20 cycles after the last word.
    do_reset();
    req0_valid = 1'b1; req0_data = 10'h101; req0_last = 1'b1;
    mid(); next();
    mid(); check("drain_accept", req0_ready, 1); next();
    req0_valid = 1'b0; req0_last = 1'b0; tx_active = 1'b1;
    for (int i = 0; i < 20; i++) begin
      mid();
      check("drain_hold_grant", grant, 2'b01);
      check("drain_hold_busy", busy, 1);
      next();
    end
    tx_active = 1'b0;
    mid(); check("drain_exit_grant", grant, 2'b01); next();
    mid(); check("drain_gap_grant", grant, 2'b00); check("drain_gap_busy", busy, 1); next();
    wait_idle("drain_idle", 200);

    // Contention: both requesters queue two frames from IDLE.
    do_reset();
    q0 = '{'{10'h100, 1'b0}, '{10'h101, 1'b1}, '{10'h102, 1'b0}, '{10'h103, 1'b1}};
    q1 = '{'{10'h200, 1'b0}, '{10'h201, 1'b1}, '{10'h202, 1'b0}, '{10'h203, 1'b1}};
`ifdef COAX_TX_SCHEDULER_ROUND_ROBIN_EN
    exp_order = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_order = '{2'b01, 2'b01, 2'b10, 2'b10};
`endif
    run_auto(1'b0, 2000);
    check("cont_frames", order.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < order.size()) check($sformatf("cont_order%0d", i), order[i], exp_order[i]);
    end

    // Reset mid-frame after the 2nd of 4 words, then a fresh req1 frame.
    do_reset();
    req0_valid = 1'b1; req0_data = 10'h011;
    mid(); next();
    mid(); check("mrst_acc1", req0_ready, 1); next();
    req0_data = 10'h022;
    mid(); next();
    mid(); check("mrst_acc2", req0_ready, 1); next();
    req0_data = 10'h033;
    check("mrst_pre_load", tx_load, 1);
    reset = 1'b1;
    #1;
    check("mrst_load", tx_load, 0);
    check("mrst_grant", grant, 2'b00);
    check("mrst_busy", busy, 0);
    check("mrst_ready", req0_ready, 0);
    check("mrst_data", tx_data, 0);
    idle_inputs();
    next(); next();
    reset = 1'b0;
    q0.delete();
    q1 = '{'{10'h2F0, 1'b0}, '{10'h2F1, 1'b1}};
    run_auto(1'b0, 500);
    check("mrst_frames", order.size(), 1);
    if (order.size() > 0) check("mrst_order", order[0], 2'b10);

    // Randomized traffic.
    for (int round = 0; round < 10; round++) begin
      do_reset();
      q0.delete();
      q1.delete();
      nf = 0;
      for (int r = 0; r < 2; r++) begin
        int frames = $urandom_range(1, 3);
        nf += frames;
        for (int f = 0; f < frames; f++) begin
          int words = $urandom_range(1, 4);
          for (int k = 0; k < words; k++) begin
            word_t w;
            w.d = 10'($urandom);
            w.l = (k == words - 1);
            if (r == 0) q0.push_back(w); else q1.push_back(w);
          end
        end
      end
      run_auto(1'b1, 5000);
      check("rand_frames", order.size(), nf);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/coax_tx_scheduler.md
COAX_TX_SCHEDULER -- requirements
Module: coax_tx_scheduler

Interface
REQ-001 SHALL provide parameter GAP_CYCLES, default 32: idle cycles enforced between consecutive frames.
REQ-002 SHALL provide port clk  input  1  single system clock; all logic is on its rising edge.
REQ-003 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide ports reqN_valid  input  1  (N=0,1)  word available from requester N.
REQ-005 SHALL provide ports reqN_data  input  10  (N=0,1)  coax word from requester N.
REQ-006 SHALL provide ports reqN_last  input  1  (N=0,1)  word is the final word of the frame.
REQ-007 SHALL provide ports reqN_ready  output  1  (N=0,1)  word accepted this cycle.
REQ-008 SHALL provide port tx_load  output  1  one-cycle load strobe to coax_tx.
REQ-009 SHALL provide port tx_data  output  10  word presented to coax_tx.
REQ-010 SHALL provide port tx_full  input  1  coax_tx cannot accept a word.
REQ-011 SHALL provide port tx_active  input  1  coax_tx is transmitting.
REQ-012 SHALL provide port grant  output  2  one-hot current owner; 00 when none.
REQ-013 SHALL provide port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement states IDLE, STREAM, DRAIN and GAP.
REQ-015 IDLE: when any reqN_valid is high, SHALL register grant to the selected requester and enter STREAM on the next edge.
REQ-016 STREAM: a word SHALL be accepted on a cycle where the granted valid=1, tx_full=0 and tx_load=0; that cycle reqN_ready=1 for the granted requester only.
REQ-017 On acceptance, SHALL register tx_load=1 and tx_data=reqN_data for exactly the next cycle, giving at most one word per two cycles.
REQ-018 tx_data SHALL hold its last value while tx_load=0.
REQ-019 Acceptance of a word with reqN_last=1 SHALL move to DRAIN; grant SHALL stay held until DRAIN exits.
REQ-020 A non-granted requester SHALL never see ready=1; a granted requester dropping valid mid-frame SHALL stall STREAM without timeout.
REQ-021 DRAIN: after a minimum of 2 cycles, SHALL exit to GAP on the first cycle with tx_active=0 and tx_full=0.
REQ-022 GAP: SHALL clear grant, count GAP_CYCLES cycles, then enter IDLE; GAP_CYCLES=0 SHALL go straight to IDLE.
REQ-023 Gap counter SHALL be wide enough for GAP_CYCLES with no wrap-around.
REQ-024 Latency: valid rising in IDLE at cycle N SHALL give grant at N+1, ready at N+1 (if tx_full=0), and tx_load at N+2.

Reset
REQ-025 Asserting reset at any time, including mid-frame, SHALL immediately force IDLE, grant=00, busy=0, tx_load=0, tx_data=0, ready=0, gap counter=0 and round-robin pointer=0; no partial frame is resumed.

Configuration
REQ-026 With COAX_TX_SCHEDULER_ROUND_ROBIN_EN defined, simultaneous requests in IDLE SHALL go to the requester named by a 1-bit pointer, which SHALL flip to the other requester when a frame granted to the pointed requester completes DRAIN.
REQ-027 Without COAX_TX_SCHEDULER_ROUND_ROBIN_EN, requester 0 SHALL always win simultaneous requests and no pointer SHALL exist.

Verification
REQ-028 Single frame: req0 sends 3 words 0x031,0x29C,0x212 (last on third), tx_full=0, tx_active pulses -> three tx_load pulses two cycles apart carrying those words in order, grant=01 throughout, then GAP of 32 cycles, then busy=0.
REQ-029 Backpressure: tx_full=1 for 10 cycles mid-frame -> no ready and no tx_load during those cycles; the held word is sent on the cycle after tx_full falls.
REQ-030 Contention: req0 and req1 valid together from IDLE, two frames each -> with the macro, grant order 01,10,01,10; without it, 01,01,10,10.
REQ-031 Drain: last word accepted while tx_active stays 1 for 20 cycles -> state remains DRAIN and grant stays held until tx_active=0, then GAP.
REQ-032 Reset mid-frame: reset asserted after the 2nd of 4 words -> same cycle tx_load=0, grant=00; after release, a new req1 frame is granted normally.
